branch_predictor: RTL and testbench

Front-end branch predictor paired with the ID-stage branch resolution. In IF it looks up the fetch PC and predicts direction and target from a direct-mapped table of 2-bit saturating counters plus a branch target buffer. In ID it compares the resolved outcome (`do_branch` and target) with the prediction carried down the pipe. On a mismatch it raises a redirect/flush, and on every resolved branch it trains the table.

---
 rtl/bp_pkg.sv | 37 +++
 rtl/bp_table.sv | 43 ++++
 rtl/branch_predictor.sv | 121 ++++++++++++
 tb/tb_branch_predictor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types, counter encodings and helpers for the branch predictor.
package bp_pkg;

    localparam int unsigned XLEN  = 32;
    // Wide enough for the tag at the smallest legal table size (4 entries).
    localparam int unsigned TAG_W = 30;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
    } bp_entry_t;

    // Saturating 2-bit direction counter update.
    function automatic logic [1:0] bp_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && (ctr != BP_ST)) begin
            nxt = ctr + 2'd1;
        end else if (!taken && (ctr != BP_SNT)) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    // Tag is pc[31:idx_w+2], zero-extended into the fixed-width field.
    function automatic logic [TAG_W-1:0] bp_tag(input logic [XLEN-1:0] pc, input int unsigned idx_w);
        return TAG_W'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped predictor entry storage: lookup read port, write port with
// read-back of the addressed entry, and a valid-bit invalidate port.
module bp_table
    import bp_pkg::*;
#(
    parameter  int unsigned ENTRIES = 64,
    localparam int unsigned IDX     = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [IDX-1:0] rd_idx,
    output bp_entry_t      rd_entry,
    input  logic           wr_en,
    input  logic [IDX-1:0] wr_idx,
    input  bp_entry_t      wr_entry,
    output bp_entry_t      wr_old,
    input  logic           inv_en,
    input  logic [IDX-1:0] inv_idx
);

    localparam bp_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: BP_WNT};

    bp_entry_t mem [ENTRIES];

    assign rd_entry = mem[rd_idx];
    assign wr_old   = mem[wr_idx];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem[IDX'(i)] <= RESET_ENTRY;
            end
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_entry;
            end
            if (inv_en) begin
                mem[inv_idx].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage direction/target prediction with ID-stage resolution, redirect,
// table training and branch/mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        id_valid_i,
    input  logic        id_stall_i,
    input  logic        id_is_branch_i,
    input  logic [31:0] id_pc_i,
    input  logic        id_pred_taken_i,
    input  logic [31:0] id_pred_target_i,
    input  logic        id_do_branch_i,
    input  logic [31:0] id_target_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    logic [IDX-1:0] if_idx;
    logic [IDX-1:0] id_idx;
    bp_entry_t      if_entry;
    bp_entry_t      id_entry;
    bp_entry_t      wr_entry;
    logic           wr_en;
    logic           inv_en;
    logic           if_hit;
    logic           id_hit;
    logic           res;
    logic           br_res;
    logic           mispredict;

    assign if_idx = if_pc_i[IDX+1:2];
    assign id_idx = id_pc_i[IDX+1:2];

    bp_table #(
        .ENTRIES (ENTRIES)
    ) u_table (
        .clk      (clk),
        .resetn   (resetn),
        .rd_idx   (if_idx),
        .rd_entry (if_entry),
        .wr_en    (wr_en),
        .wr_idx   (id_idx),
        .wr_entry (wr_entry),
        .wr_old   (id_entry),
        .inv_en   (inv_en),
        .inv_idx  (id_idx)
    );

    // Fetch-side lookup; reads pre-write contents on a same-index update.
    assign if_hit        = if_entry.valid && (if_entry.tag == bp_tag(if_pc_i, IDX));
    assign pred_taken_o  = if_hit && (if_entry.ctr >= BP_WT);
    assign pred_target_o = pred_taken_o ? if_entry.target : 32'h0;

    assign res        = id_valid_i && !id_stall_i;
    assign br_res     = res && id_is_branch_i;
    assign id_hit     = id_entry.valid && (id_entry.tag == bp_tag(id_pc_i, IDX));
    assign mispredict = (id_pred_taken_i != id_do_branch_i) ||
                        (id_pred_taken_i && id_do_branch_i && (id_pred_target_i != id_target_i));
    assign inv_en     = res && !id_is_branch_i && id_pred_taken_i;

    // Redirect; +8 skips the delay slot, +4 falls through a bogus taken prediction.
    always_comb begin
        redirect_o    = 1'b0;
        redirect_pc_o = 32'h0;
        if (resetn && res) begin
            if (id_is_branch_i) begin
                if (mispredict) begin
                    redirect_o    = 1'b1;
                    redirect_pc_o = id_do_branch_i ? id_target_i : (id_pc_i + 32'd8);
                end
            end else if (id_pred_taken_i) begin
                redirect_o    = 1'b1;
                redirect_pc_o = id_pc_i + 32'd4;
            end
        end
    end

    // Training: update on hit, allocate weakly-taken on a taken miss.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = id_entry;
        if (br_res) begin
            if (id_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = bp_ctr_next(id_entry.ctr, id_do_branch_i);
                if (id_do_branch_i) begin
                    wr_entry.target = id_target_i;
                end
            end else if (id_do_branch_i) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: bp_tag(id_pc_i, IDX), target: id_target_i, ctr: BP_WT};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branch_cnt_o  <= 32'h0;
            mispred_cnt_o <= 32'h0;
        end else begin
            if (br_res) begin
                branch_cnt_o <= branch_cnt_o + 32'd1;
            end
            if (redirect_o) begin
                mispred_cnt_o <= mispred_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus random traffic against a
// per-index behavioural model of the predictor table.
module tb_branch_predictor;

    localparam int unsigned ENTRIES = 64;
    localparam int unsigned IDX     = 6;

    logic        clk;
    logic        resetn;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid;
    logic        id_stall;
    logic        id_is_branch;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        id_do_branch;
    logic [31:0] id_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .if_pc_i          (if_pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .id_valid_i       (id_valid),
        .id_stall_i       (id_stall),
        .id_is_branch_i   (id_is_branch),
        .id_pc_i          (id_pc),
        .id_pred_taken_i  (id_pred_taken),
        .id_pred_target_i (id_pred_target),
        .id_do_branch_i   (id_do_branch),
        .id_target_i      (id_target),
        .redirect_o       (redirect),
        .redirect_pc_o    (redirect_pc),
        .branch_cnt_o     (branch_cnt),
        .mispred_cnt_o    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per table slot, counters as plain integers.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pc_pool  [8];
    logic [31:0] tgt_pool [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned m_index(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int unsigned i;
        i = m_index(pc);
        return m_valid[i] && (m_tag[i] == (pc >> (IDX + 2)));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[m_index(pc)] : 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'h0;
            m_tgt[i]   = 32'h0;
            m_ctr[i]   = 1;
        end
        m_bcnt = 32'h0;
        m_mcnt = 32'h0;
    endtask

    // One clock: drive at negedge, check combinational and counter outputs, update model after the edge.
    task automatic cycle(input logic [31:0] ifpc, input logic v, input logic st, input logic br,
                         input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                         input logic db, input logic [31:0] tg);
        bit          res;
        bit          exp_red;
        logic [31:0] exp_rpc;
        int unsigned i;
        if_pc = ifpc; id_valid = v; id_stall = st; id_is_branch = br; id_pc = pc;
        id_pred_taken = pt; id_pred_target = ptg; id_do_branch = db; id_target = tg;
        #1;
        res     = v && !st;
        exp_red = 1'b0;
        exp_rpc = 32'h0;
        if (res && br) begin
            if ((pt != db) || (pt && db && (ptg != tg))) begin
                exp_red = 1'b1;
                exp_rpc = db ? tg : pc + 32'd8;
            end
        end else if (res && pt) begin
            exp_red = 1'b1;
            exp_rpc = pc + 32'd4;
        end
        check("pred_taken",  32'(pred_taken), 32'(m_pred(ifpc)));
        check("pred_target", pred_target, m_ptgt(ifpc));
        check("redirect",    32'(redirect), 32'(exp_red));
        check("redirect_pc", redirect_pc, exp_rpc);
        check("branch_cnt",  branch_cnt, m_bcnt);
        check("mispred_cnt", mispred_cnt, m_mcnt);
        @(posedge clk);
        i = m_index(pc);
        if (res && br) begin
            m_bcnt++;
            if (m_hit(pc)) begin
                m_ctr[i] = db ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                if (db) m_tgt[i] = tg;
            end else if (db) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = pc >> (IDX + 2);
                m_tgt[i]   = tg;
                m_ctr[i]   = 2;
            end
        end else if (res && pt) begin
            m_valid[i] = 1'b0;
        end
        if (exp_red) m_mcnt++;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] ifpc);
        cycle(ifpc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Asynchronous reset in the middle of a clock phase with a mispredicting branch in ID.
    task automatic async_reset();
        if_pc = 32'h8000_1000; id_valid = 1'b1; id_stall = 1'b0; id_is_branch = 1'b1;
        id_pc = 32'h8000_1000; id_pred_taken = 1'b0; id_pred_target = 32'h0;
        id_do_branch = 1'b1; id_target = 32'h8000_2000;
        #1 resetn = 1'b0;
        #1;
        model_reset();
        check("rst_pred_taken",  32'(pred_taken), 32'h0);
        check("rst_pred_target", pred_target, 32'h0);
        check("rst_redirect",    32'(redirect), 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_branch_cnt",  branch_cnt, 32'h0);
        check("rst_mispred_cnt", mispred_cnt, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_pred", 32'(pred_taken), 32'h0);
        check("rst_hold_bcnt", branch_cnt, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] r_pc;
        logic        r_pt;
        logic [31:0] r_ptg;
        pc_pool  = '{32'h8000_1000, 32'h8001_1000, 32'h8000_1004, 32'h8000_4000,
                     32'h8000_2000, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_013C};
        tgt_pool = '{32'h8000_2000, 32'h8000_3000, 32'h0000_0100, 32'h8000_1008};
        resetn = 1'b0;
        if_pc = 32'h0; id_valid = 1'b0; id_stall = 1'b0; id_is_branch = 1'b0; id_pc = 32'h0;
        id_pred_taken = 1'b0; id_pred_target = 32'h0; id_do_branch = 1'b0; id_target = 32'h0;
        model_reset();
        @(negedge clk);
        async_reset();

        idle(32'hBFC0_0000);
        // Allocate on a taken miss, then predict it.
        cycle(32'h8000_1000, 1, 0, 1, 32'h8000_1000, 0, 32'h0, 1, 32'h8000_2000);
        idle(32'h8000_1000);
        // Two not-taken resolutions: 10 -> 01 -> 00, then one taken leaves it not-taken.
        cycle(32'h8000_1000, 1, 0, 1, 32'h8000_1000, 1, 32'h8000_2000, 0, 32'h0);
        cycle(32'h8000_1000, 1, 0, 1, 32'h8000_1000, 0, 32'h0, 0, 32'h0);
        cycle(32'h8000_1000, 1, 0, 1, 32'h8000_1000, 0, 32'h0, 1, 32'h8000_2000);
        idle(32'h8000_1000);
        cycle(32'h8000_1000, 1, 0, 1, 32'h8000_1000, 0, 32'h0, 1, 32'h8000_2000);
        idle(32'h8000_1000);
        // Saturate at 11 and retarget on a hit.
        cycle(32'h8000_1000, 1, 0, 1, 32'h8000_1000, 1, 32'h8000_2000, 1, 32'h8000_2000);
        cycle(32'h8000_1000, 1, 0, 1, 32'h8000_1000, 1, 32'h8000_2000, 1, 32'h8000_2000);
        cycle(32'h8000_1000, 1, 0, 1, 32'h8000_1000, 1, 32'h8000_2000, 1, 32'h8000_2400);
        idle(32'h8000_1000);
        // Aliasing on the same index with a different tag.
        idle(32'h8001_1000);
        cycle(32'h8001_1000, 1, 0, 1, 32'h8001_1000, 0, 32'h0, 1, 32'h8000_3000);
        idle(32'h8000_1000);
        idle(32'h8001_1000);
        // Stalled mispredicting branch held for three cycles.
        for (int k = 0; k < 3; k++) begin
            cycle(32'h8000_5000, 1, 1, 1, 32'h8000_5000, 0, 32'h0, 1, 32'h8000_6000);
        end
        cycle(32'h8000_5000, 1, 0, 1, 32'h8000_5000, 0, 32'h0, 1, 32'h8000_6000);
        idle(32'h8000_5000);
        // Non-branch predicted taken invalidates its entry.
        cycle(32'h8000_4000, 1, 0, 1, 32'h8000_4000, 0, 32'h0, 1, 32'h8000_4100);
        cycle(32'h8000_4000, 1, 0, 0, 32'h8000_4000, 1, 32'h8000_4100, 0, 32'h0);
        idle(32'h8000_4000);
        // Fall-through addresses wrap modulo 2^32.
        cycle(32'h0, 1, 0, 1, 32'hFFFF_FFF8, 1, 32'h8000_0000, 0, 32'h0);
        cycle(32'h0, 1, 0, 0, 32'hFFFF_FFFC, 1, 32'h8000_0000, 0, 32'h0);

        for (int n = 0; n < 1500; n++) begin
            if (n == 700) async_reset();
            r_pc = pc_pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) != 0) begin
                r_pt  = m_pred(r_pc);
                r_ptg = m_ptgt(r_pc);
            end else begin
                r_pt  = 1'($urandom_range(0, 1));
                r_ptg = tgt_pool[$urandom_range(0, 3)];
            end
            cycle(pc_pool[$urandom_range(0, 7)], 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) != 0),
                  r_pc, r_pt, r_ptg, 1'($urandom_range(0, 1)), tgt_pool[$urandom_range(0, 3)]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
